// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control: FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshake,
// wait timeout, illegal-opcode pulse and retire counter. `CTRL_ITYPE_ALU_EN enables I-type ALU.
module multicycle_control_fsm #(
    parameter int unsigned OPCODE_W    = 5,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    input  logic                zero_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                iord_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                pc_write_br_o,
    output logic                branch_o,
    output logic                alu_src_o,
    output logic [ALUOP_W-1:0]  alu_op_o,
    output logic                reg_write_o,
    output logic                mem_to_reg_o,
    output logic                illegal_o,
    output logic                mem_err_o,
    output logic [CNT_W-1:0]    instr_count_o
);

    localparam int unsigned WaitW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit          TimeoutEn = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;
    typedef enum logic [2:0] {KindR, KindLoad, KindStore, KindBranch, KindItype} kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic              run_q;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic              timeout;
    logic              retire;

    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        iord_o        = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        pc_write_br_o = 1'b0;
        branch_o      = 1'b0;
        alu_src_o     = 1'b0;
        alu_op_o      = '0;
        reg_write_o   = 1'b0;
        mem_to_reg_o  = 1'b0;
        illegal_o     = 1'b0;
        mem_err_o     = 1'b0;
        state_d       = state_q;
        kind_d        = kind_q;
        timeout       = 1'b0;
        retire        = 1'b0;

        // run_q holds everything quiet for the first cycle after reset release
        if (run_q) begin
            if (state_q == StFetch || state_q == StMem) begin
                timeout = TimeoutEn && !mem_ready_i && (wait_cnt_q == WaitW'(MEM_TIMEOUT));
            end
            unique case (state_q)
                StFetch: begin
                    mem_req_o = !timeout;
                    mem_err_o = timeout;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        state_d    = StDecode;
                    end
                end
                StDecode: begin
                    state_d = StExec;
                    case (opcode_i)
                        OPCODE_W'(5'b01100): kind_d = KindR;
                        OPCODE_W'(5'b00000): kind_d = KindLoad;
                        OPCODE_W'(5'b01000): kind_d = KindStore;
                        OPCODE_W'(5'b11000): kind_d = KindBranch;
`ifdef CTRL_ITYPE_ALU_EN
                        OPCODE_W'(5'b00100): kind_d = KindItype;
`endif
                        default: begin
                            illegal_o = 1'b1;
                            state_d   = StFetch;
                        end
                    endcase
                end
                StExec: begin
                    unique case (kind_q)
                        KindR: begin
                            alu_op_o = ALUOP_W'(2'b10);
                            state_d  = StWb;
                        end
                        KindItype: begin
                            alu_src_o = 1'b1;
                            alu_op_o  = ALUOP_W'(2'b10);
                            state_d   = StWb;
                        end
                        KindLoad, KindStore: begin
                            alu_src_o = 1'b1;
                            state_d   = StMem;
                        end
                        default: begin
                            alu_op_o      = ALUOP_W'(2'b01);
                            branch_o      = 1'b1;
                            pc_write_br_o = zero_i;
                            retire        = 1'b1;
                            state_d       = StFetch;
                        end
                    endcase
                end
                StMem: begin
                    mem_req_o = !timeout;
                    mem_we_o  = !timeout && (kind_q == KindStore);
                    iord_o    = 1'b1;
                    mem_err_o = timeout;
                    if (mem_ready_i) begin
                        if (kind_q == KindStore) begin
                            retire  = 1'b1;
                            state_d = StFetch;
                        end else begin
                            state_d = StWb;
                        end
                    end else if (timeout) begin
                        state_d = StFetch;
                    end
                end
                default: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = (kind_q == KindLoad);
                    retire       = 1'b1;
                    state_d      = StFetch;
                end
            endcase
        end

        // A FETCH timeout stays in FETCH, so it must clear the counter explicitly
        if (state_d != state_q || timeout) begin
            wait_cnt_d = '0;
        end else if (run_q && (state_q == StFetch || state_q == StMem) && !mem_ready_i) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        instr_count_d = retire ? instr_count_q + CNT_W'(1) : instr_count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StFetch;
            kind_q        <= KindR;
            run_q         <= 1'b0;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            run_q         <= 1'b1;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (MEM_TIMEOUT=4); honours CTRL_ITYPE_ALU_EN.
module tb_multicycle_control_fsm;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  opcode_i;
    logic        mem_ready_i;
    logic        zero_i;
    logic        mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_br_o;
    logic        branch_o, alu_src_o, reg_write_o, mem_to_reg_o, illegal_o, mem_err_o;
    logic [1:0]  alu_op_o;
    logic [31:0] instr_count_o;

    int errors = 0;
    int checks = 0;

    multicycle_control_fsm #(
        .OPCODE_W   (5),
        .ALUOP_W    (2),
        .CNT_W      (32),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .opcode_i     (opcode_i),
        .mem_ready_i  (mem_ready_i),
        .zero_i       (zero_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .iord_o       (iord_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_write_br_o(pc_write_br_o),
        .branch_o     (branch_o),
        .alu_src_o    (alu_src_o),
        .alu_op_o     (alu_op_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .illegal_o    (illegal_o),
        .mem_err_o    (mem_err_o),
        .instr_count_o(instr_count_o)
    );

    always #5 clk_i = ~clk_i;

    logic [13:0] outv;
    assign outv = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_br_o,
                   branch_o, alu_src_o, alu_op_o, reg_write_o, mem_to_reg_o, illegal_o,
                   mem_err_o};

    function automatic logic [13:0] v(input logic req, input logic we, input logic iord,
                                      input logic irw, input logic pcw, input logic pcbr,
                                      input logic br, input logic asrc, input logic [1:0] aop,
                                      input logic rw, input logic m2r, input logic ill,
                                      input logic err);
        return {req, we, iord, irw, pcw, pcbr, br, asrc, aop, rw, m2r, ill, err};
    endfunction

    logic [13:0] NONE, FW, FR, ER, ELS, EB1, EB0, MWL, MWS, WR, WL, TO, ILL, EI;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check outputs 1ns later
    task automatic cyc(input logic rdy, input logic z, input string tag, input logic [13:0] e);
        @(negedge clk_i);
        mem_ready_i = rdy;
        zero_i      = z;
        #1;
        chk(tag, {18'd0, outv}, {18'd0, e});
    endtask

    initial begin
        int exp_cnt;
        NONE = '0;
        FW   = v(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        FR   = v(1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        ER   = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
        ELS  = v(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        EB1  = v(0, 0, 0, 0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0);
        EB0  = v(0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0);
        MWL  = v(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        MWS  = v(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        WR   = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        WL   = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0);
        TO   = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        ILL  = v(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        EI   = v(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);

        rst_ni      = 1'b0;
        opcode_i    = 5'b01100;
        mem_ready_i = 1'b1;
        zero_i      = 1'b0;

        // Reset held three cycles, mem_ready high to show it is ignored
        for (int i = 0; i < 3; i++) cyc(1, 0, "rst_outputs", NONE);
        chk("rst_count", instr_count_o, 32'd0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        mem_ready_i = 1'b0;
        #1;
        chk("release_quiet", {18'd0, outv}, 32'd0);
        cyc(0, 0, "fetch_first", FW);

        // R-type
        cyc(1, 0, "r_fetch", FR);
        cyc(1, 0, "r_decode", NONE);
        cyc(1, 0, "r_exec", ER);
        cyc(1, 0, "r_wb", WR);
        chk("r_count_before", instr_count_o, 32'd0);

        // Load with two MEM wait cycles
        opcode_i = 5'b00000;
        cyc(1, 0, "ld_fetch", FR);
        chk("r_count_after", instr_count_o, 32'd1);
        cyc(1, 0, "ld_decode", NONE);
        cyc(1, 0, "ld_exec", ELS);
        cyc(0, 0, "ld_mem_w0", MWL);
        cyc(0, 0, "ld_mem_w1", MWL);
        cyc(1, 0, "ld_mem_rdy", MWL);
        cyc(1, 0, "ld_wb", WL);

        // Store
        opcode_i = 5'b01000;
        cyc(1, 0, "st_fetch", FR);
        chk("ld_count", instr_count_o, 32'd2);
        cyc(1, 0, "st_decode", NONE);
        cyc(1, 0, "st_exec", ELS);
        cyc(1, 0, "st_mem", MWS);

        // Branch taken then not taken
        opcode_i = 5'b11000;
        cyc(1, 0, "br1_fetch", FR);
        chk("st_count", instr_count_o, 32'd3);
        cyc(1, 0, "br1_decode", NONE);
        cyc(1, 1, "br1_exec_zero", EB1);
        cyc(1, 0, "br0_fetch", FR);
        chk("br1_count", instr_count_o, 32'd4);
        cyc(1, 0, "br0_decode", NONE);
        cyc(1, 0, "br0_exec_nz", EB0);

        // FETCH timeout after four unanswered cycles
        opcode_i = 5'b00100;
        cyc(0, 0, "to_wait0", FW);
        chk("br0_count", instr_count_o, 32'd5);
        cyc(0, 0, "to_wait1", FW);
        cyc(0, 0, "to_wait2", FW);
        cyc(0, 0, "to_wait3", FW);
        cyc(0, 0, "to_err", TO);
        cyc(0, 0, "to_refetch", FW);
        chk("to_count", instr_count_o, 32'd5);

        // mem_ready at the timeout limit completes the fetch
        cyc(0, 0, "race_wait1", FW);
        cyc(0, 0, "race_wait2", FW);
        cyc(0, 0, "race_wait3", FW);
        cyc(1, 0, "race_ready", FR);

`ifdef CTRL_ITYPE_ALU_EN
        cyc(1, 0, "it_decode", NONE);
        cyc(1, 0, "it_exec", EI);
        cyc(1, 0, "it_wb", WR);
        exp_cnt = 6;
`else
        cyc(1, 0, "it_illegal", ILL);
        exp_cnt = 5;
`endif
        cyc(0, 0, "it_back_fetch", FW);
        chk("it_count", instr_count_o, exp_cnt);

        // Reset mid-instruction aborts it
        opcode_i = 5'b01100;
        cyc(1, 0, "ab_fetch", FR);
        cyc(1, 0, "ab_decode", NONE);
        cyc(1, 0, "ab_exec", ER);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("ab_rst_outputs", {18'd0, outv}, 32'd0);
        chk("ab_rst_count", instr_count_o, 32'd0);
        cyc(1, 0, "ab_rst_hold", NONE);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        mem_ready_i = 1'b0;
        cyc(0, 0, "ab_restart", FW);
        chk("ab_restart_count", instr_count_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
